frqdiv_prog: RTL and testbench

Multi-channel, run-time programmable integer clock divider for the synth tone and modulation path. Each channel produces two outputs from the system clock:
- a near-50% square-wave enable, `s_out`
- a one-cycle period strobe, `tick`

Divisors are written at run time through a single write port. A new divisor takes effect only at the end of the current period, so output changes are glitch-free. All logic runs on `clk` rising edge only; there is no negedge or derived-clock logic.

---
 rtl/frqdiv_prog.sv | 170 +++++++++++++++++
 tb/tb_frqdiv_prog.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frqdiv_prog.sv
// ---------------------------------------------------------------------------
// frqdiv_prog -- multi-channel, run-time programmable integer clock divider.
//
// Every channel divides clk by an integer divisor D and produces:
//   s_out : square-wave enable. It is low for ceil(D/2) cycles and then high
//           for floor(D/2) cycles. D=1 gives a constant 1. D=0 stops the
//           channel and holds s_out at 0.
//   tick  : one-cycle strobe on the last cycle of each period.
//   pend  : a divisor has been written but is not yet active.
//
// A new divisor is first held in a shadow register. It moves to the active
// register only at a period boundary, or when sync is applied, so the
// outputs never show a truncated or stretched period.
//
// Ports:
//   clk      in   1      system clock, rising edge only
//   rst_n    in   1      asynchronous active-low reset
//   div_we   in   1      divisor write strobe
//   div_ch   in   CHW    channel addressed by the write (>= CH is ignored)
//   div_val  in   WIDTH  divisor value (0 = stop)
//   sync     in   CH     per-channel phase reset, level-sampled
//   s_out    out  CH     per-channel square-wave output
//   tick     out  CH     per-channel end-of-period strobe
//   pend     out  CH     per-channel divisor-pending flag
//
// All outputs are decoded from registers only. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module frqdiv_prog #(
    parameter int WIDTH = 16,
    parameter int CH    = 4,
    parameter int CHW   = ($clog2(CH) > 0) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_we,
    input  logic [CHW-1:0]   div_ch,
    input  logic [WIDTH-1:0] div_val,
    input  logic [CH-1:0]    sync,
    output logic [CH-1:0]    s_out,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    pend
);

    // -----------------------------------------------------------------------
    // Per-channel state
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] act_q    [CH];   // active divisor
    logic [WIDTH-1:0] act_d    [CH];
    logic [WIDTH-1:0] shadow_q [CH];   // divisor waiting for a boundary
    logic [WIDTH-1:0] shadow_d [CH];
    logic [WIDTH-1:0] cnt_q    [CH];   // phase counter, 0 .. act-1
    logic [WIDTH-1:0] cnt_d    [CH];
    logic [CH-1:0]    pend_q;
    logic [CH-1:0]    pend_d;

    // -----------------------------------------------------------------------
    // Decode from the registers
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] half_up  [CH];   // ceil(act/2)
    logic [CH-1:0]    last;            // cnt is on the final cycle of the period
    logic [CH-1:0]    boundary;        // an edge here may load shadow into act
    logic [CH-1:0]    wr_hit;          // this cycle's write targets channel c

    // NOTE: every variable written in an always_comb gets a default at the
    // top of the block. Otherwise, a path that skips an assignment infers a
    // latch.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            half_up[c]  = (act_q[c] >> 1) + {{(WIDTH-1){1'b0}}, act_q[c][0]};
            last[c]     = (act_q[c] != '0) && (cnt_q[c] == act_q[c] - WIDTH'(1));
            boundary[c] = last[c] || (act_q[c] == '0);

            // s_out is a special case for act=0 and act=1. The threshold
            // compare would give 0 for act=1, but that channel must be
            // constantly high.
            if (act_q[c] == '0) begin
                s_out[c] = 1'b0;
            end else if (act_q[c] == WIDTH'(1)) begin
                s_out[c] = 1'b1;
            end else begin
                s_out[c] = (cnt_q[c] >= half_up[c]);
            end
            tick[c] = last[c];
        end
        pend = pend_q;
    end

    // A channel index at or above CH never matches, so an out-of-range write
    // changes no state.
    always_comb begin
        wr_hit = '0;
        for (int c = 0; c < CH; c++) begin
            wr_hit[c] = div_we && (div_ch == CHW'(c));
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            act_d[c]    = act_q[c];
            shadow_d[c] = shadow_q[c];
            cnt_d[c]    = cnt_q[c];
            pend_d[c]   = pend_q[c];

            if (sync[c]) begin
                // Sync overrides wrap and boundary handling. A write in the
                // same cycle bypasses the shadow and takes effect at once.
                cnt_d[c] = '0;
                if (wr_hit[c]) begin
                    act_d[c]    = div_val;
                    shadow_d[c] = div_val;
                    pend_d[c]   = 1'b0;
                end else if (pend_q[c]) begin
                    act_d[c]  = shadow_q[c];
                    pend_d[c] = 1'b0;
                end
            end else begin
                if (boundary[c] && pend_q[c]) begin
                    act_d[c]  = shadow_q[c];
                    cnt_d[c]  = '0;
                    pend_d[c] = 1'b0;
                end else if (act_q[c] > WIDTH'(1)) begin
                    cnt_d[c] = last[c] ? '0 : cnt_q[c] + WIDTH'(1);
                end else begin
                    cnt_d[c] = '0;
                end

                // A write that lands on a boundary cycle goes only to the
                // shadow register. It sets pend again, so the new value is
                // applied at the following boundary. If a stale shadow value
                // is loaded at this edge, that still happens.
                if (wr_hit[c]) begin
                    shadow_d[c] = div_val;
                    pend_d[c]   = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: the per-channel arrays are reset element by element. They are
    // control state that the outputs decode from, not a data memory, so no
    // element may come up unknown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                act_q[c]    <= '0;
                shadow_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            pend_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment. All flops
            // then sample their _d values from before the edge, whatever the
            // statement order.
            for (int c = 0; c < CH; c++) begin
                act_q[c]    <= act_d[c];
                shadow_q[c] <= shadow_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_frqdiv_prog.sv
// ---------------------------------------------------------------------------
// tb_frqdiv_prog -- directed testbench for frqdiv_prog.
//
// The main instance is the default build (WIDTH=16, CH=4). A second instance
// (WIDTH=8, CH=3) provides a channel index that is out of range. Every
// expected value below is worked out by hand from the divider behaviour.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, so each sample shows the state after that edge.
// ---------------------------------------------------------------------------
module tb_frqdiv_prog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_we = 1'b0;
    logic [1:0]  div_ch = '0;
    logic [15:0] div_val = '0;
    logic [3:0]  sync = '0;
    logic [3:0]  s_out, tick, pend;

    logic        we3 = 1'b0;
    logic [1:0]  ch3 = '0;
    logic [7:0]  val3 = '0;
    logic [2:0]  sync3 = '0;
    logic [2:0]  s_out3, tick3, pend3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frqdiv_prog #(.WIDTH(16), .CH(4)) uut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_we (div_we),
        .div_ch (div_ch),
        .div_val(div_val),
        .sync   (sync),
        .s_out  (s_out),
        .tick   (tick),
        .pend   (pend)
    );

    frqdiv_prog #(.WIDTH(8), .CH(3)) uut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_we (we3),
        .div_ch (ch3),
        .div_val(val3),
        .sync   (sync3),
        .s_out  (s_out3),
        .tick   (tick3),
        .pend   (pend3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle write on the main instance. Returns after the write edge.
    task automatic wr(input logic [1:0] ch, input logic [15:0] v);
        div_we  = 1'b1;
        div_ch  = ch;
        div_val = v;
        step();
        div_we  = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        step();
        step();
        check("rst_s_out", s_out, 4'b0000);
        check("rst_tick", tick, 4'b0000);
        check("rst_pend", pend, 4'b0000);
        check("rst_s_out3", s_out3, 3'b000);
        rst_n = 1'b1;
        step();
        check("idle_s_out", s_out, 4'b0000);
        check("idle_tick", tick, 4'b0000);

        // ---------------- 1: ch0 D=4 ----------------
        wr(2'd0, 16'd4);
        check("t1_pend_set", pend, 4'b0001);
        check("t1_s_out_pre", s_out, 4'b0000);
        step();                                    // act0=4, cnt0=0
        check("t1_pend_clr", pend, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            check("t1_s_out", s_out, {3'b000, (i % 4) >= 2});
            check("t1_tick", tick, {3'b000, (i % 4) == 3});
            step();
        end

        // ---------------- 2: ch1 D=3 then D=5 ----------------
        wr(2'd1, 16'd3);
        step();                                    // act1=3, cnt1=0
        check("t2_s_c0", s_out[1], 1'b0);
        wr(2'd1, 16'd5);                           // issued at cnt=0 -> cnt=1
        check("t2_pend_a", pend[1], 1'b1);
        check("t2_s_c1", s_out[1], 1'b0);
        check("t2_tick_c1", tick[1], 1'b0);
        step();                                    // cnt=2, end of old period
        check("t2_s_c2", s_out[1], 1'b1);
        check("t2_tick_c2", tick[1], 1'b1);
        check("t2_pend_b", pend[1], 1'b1);
        step();                                    // act1=5, cnt=0
        check("t2_pend_clr", pend[1], 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t2_s5", s_out[1], i >= 3);
            check("t2_tick5", tick[1], i == 4);
            step();
        end
        // Back to D=3, then write D=5 on the boundary cycle.
        wr(2'd1, 16'd3);                           // cnt=1 of the D=5 period
        repeat (4) step();                         // act1=3, cnt=0
        check("t2_back3_pend", pend[1], 1'b0);
        step();
        step();                                    // cnt=2, boundary
        check("t2_bnd_tick", tick[1], 1'b1);
        wr(2'd1, 16'd5);                           // not applied here
        check("t2_bnd_pend", pend[1], 1'b1);
        check("t2_bnd_s", s_out[1], 1'b0);
        check("t2_bnd_tick0", tick[1], 1'b0);
        for (int i = 0; i < 3; i++) begin          // extra D=3 period
            check("t2_extra_s", s_out[1], i == 2);
            check("t2_extra_tick", tick[1], i == 2);
            step();
        end
        check("t2_apply_pend", pend[1], 1'b0);     // act1=5, cnt=0
        repeat (3) step();                         // cnt=3
        check("t2_apply_s", s_out[1], 1'b1);

        // ---------------- 3: ch2 D=1 then D=0 ----------------
        wr(2'd2, 16'd1);
        check("t3_pend", pend[2], 1'b1);
        step();                                    // act2=1
        check("t3_s1", s_out[2], 1'b1);
        check("t3_tick1", tick[2], 1'b1);
        check("t3_pend_clr", pend[2], 1'b0);
        repeat (2) begin
            step();
            check("t3_s1_run", s_out[2], 1'b1);
            check("t3_tick1_run", tick[2], 1'b1);
        end
        wr(2'd2, 16'd0);                           // write on a boundary cycle
        check("t3_s_hold", s_out[2], 1'b1);
        check("t3_tick_hold", tick[2], 1'b1);
        check("t3_pend0", pend[2], 1'b1);
        step();                                    // act2=0
        check("t3_s_stop", s_out[2], 1'b0);
        check("t3_tick_stop", tick[2], 1'b0);
        check("t3_pend_stop", pend[2], 1'b0);
        step();
        check("t3_s_stop2", s_out[2], 1'b0);

        // ---------------- 4: ch3 D=8 with sync ----------------
        wr(2'd3, 16'd8);
        step();                                    // act3=8, cnt=0
        repeat (5) step();                         // cnt=5
        check("t4_s_c5", s_out[3], 1'b1);
        check("t4_tick_c5", tick[3], 1'b0);
        sync = 4'b1000;
        step();                                    // cnt=0
        sync = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            check("t4_s_low", s_out[3], 1'b0);
            step();
        end
        check("t4_s_high", s_out[3], 1'b1);        // cnt=4
        div_we  = 1'b1;
        div_ch  = 2'd3;
        div_val = 16'd6;
        sync    = 4'b1000;
        step();                                    // act3=6 immediately
        div_we  = 1'b0;
        sync    = 4'b0000;
        check("t4_ws_pend", pend[3], 1'b0);
        check("t4_ws_s", s_out[3], 1'b0);
        repeat (3) step();                         // cnt=3
        check("t4_d6_s", s_out[3], 1'b1);
        repeat (2) step();                         // cnt=5
        check("t4_d6_tick", tick[3], 1'b1);
        step();                                    // cnt=0
        check("t4_d6_wrap", tick[3], 1'b0);

        // ---------------- 5: two writes, out-of-range write ----------------
        sync = 4'b0001;
        step();                                    // ch0 cnt=0, act=4
        sync = 4'b0000;
        wr(2'd0, 16'd10);                          // cnt=1
        wr(2'd0, 16'd7);                           // cnt=2
        check("t5_pend", pend[0], 1'b1);
        step();                                    // cnt=3
        check("t5_tick_old", tick[0], 1'b1);
        step();                                    // act0=7, cnt=0
        check("t5_pend_clr", pend[0], 1'b0);
        repeat (5) step();                         // cnt=5
        check("t5_tick_c5", tick[0], 1'b0);
        check("t5_s_c5", s_out[0], 1'b1);
        step();                                    // cnt=6
        check("t5_tick_c6", tick[0], 1'b1);

        we3  = 1'b1;
        ch3  = 2'd0;
        val3 = 8'd2;
        step();
        we3  = 1'b0;
        step();                                    // uut3 ch0 act=2, cnt=0
        check("t5_u3_s0", s_out3, 3'b000);
        check("t5_u3_pend0", pend3, 3'b000);
        we3  = 1'b1;
        ch3  = 2'd3;
        val3 = 8'd5;
        step();                                    // cnt=1, write ignored
        we3  = 1'b0;
        check("t5_oor_pend", pend3, 3'b000);
        check("t5_oor_s", s_out3, 3'b001);
        check("t5_oor_tick", tick3, 3'b001);
        step();
        check("t5_oor_s2", s_out3, 3'b000);
        check("t5_oor_pend2", pend3, 3'b000);
        repeat (3) step();                         // cnt=1
        check("t5_oor_s3", s_out3, 3'b001);
        check("t5_oor_tick3", tick3, 3'b001);

        // ---------------- 6: asynchronous reset mid-period ----------------
        wr(2'd2, 16'd9);
        check("t6_pre_pend", pend, 4'b0100);
        #3;
        rst_n = 1'b0;                              // no clock edge nearby
        #1;
        check("t6_async_s", s_out, 4'b0000);
        check("t6_async_tick", tick, 4'b0000);
        check("t6_async_pend", pend, 4'b0000);
        check("t6_async_s3", s_out3, 3'b000);
        check("t6_async_tick3", tick3, 3'b000);
        #2;
        rst_n = 1'b1;
        step();
        check("t6_post_s", s_out, 4'b0000);
        repeat (4) step();
        check("t6_stop_s", s_out, 4'b0000);
        check("t6_stop_tick", tick, 4'b0000);
        check("t6_stop_pend", pend, 4'b0000);
        wr(2'd1, 16'd2);
        step();                                    // act1=2, cnt=0
        check("t6_new_tick0", tick, 4'b0000);
        step();                                    // cnt=1
        check("t6_new_tick1", tick, 4'b0010);
        check("t6_new_s1", s_out, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
